// File: rtl/a2d_pkg.sv
// Shared types, widths and helpers for the A2D SPI responder.
// Noise helpers are only referenced when A2D_NOISE_EN is defined.
package a2d_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int CH_W       = 3;
    localparam int RES_W      = 12;
    localparam int BCNT_W     = 5;

    localparam logic [BCNT_W-1:0] BIT_GOOD = 5'd16;
    localparam logic [BCNT_W-1:0] BIT_SAT  = 5'd17;
    localparam logic [15:0]       LFSR_SEED = 16'hACE1;

    // Fibonacci form, taps 16,14,13,11 (maximal length)
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [RES_W-1:0] add_noise(input logic [RES_W-1:0] v,
                                                   input logic [3:0]       n);
        logic [RES_W+1:0] sum;
        sum = {2'b00, v} + {{(RES_W-2){n[3]}}, n};
        // sum spans -8..4102, so bit 13 flags negative and bit 12 flags overflow
        if (sum[RES_W+1])
            return '0;
        else if (sum[RES_W])
            return '1;
        else
            return sum[RES_W-1:0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer chain for one asynchronous SPI pin, with rise/fall detect
// on the synchronized value.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {SYNC_STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D converter (CPOL=1, CPHA=1).
// Define A2D_NOISE_EN to add LFSR dither to each returned sample.
//
// state | meaning
// IDLE  | SS_n high, MISO parked at 1, waiting for SS_n fall
// SHIFT | frame active: sample MOSI on SCLK rise, shift MISO on SCLK fall
module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter logic [11:0] RST_VAL     = 12'h000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [11:0] wr_data,
    output logic        xact_done,
    output logic        frame_err,
    output logic [2:0]  last_chnnl,
    output logic [15:0] xact_cnt
);

    logic ss_s, ss_rise, ss_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .d_i(SS_n),
        .sync_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(SCLK),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(MOSI),
        .sync_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    logic unused_ok;
    assign unused_ok = ^{ss_s, sclk_s, mosi_rise, mosi_fall};

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    // The frame MSB is shifted out before it could matter, so it is not kept.
    logic [FRAME_BITS-2:0]   rx_q, rx_d;
    logic [BCNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [RES_W-1:0]        pend_q, pend_d;
    logic [CH_W-1:0]         last_q, last_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [RES_W-1:0]        tbl_q [8];
    logic [CH_W-1:0]         rx_ch;
    logic [RES_W-1:0]        sampled;
    logic [RES_W-1:0]        pend_new;

    assign rx_ch   = rx_q[13:11];
    assign sampled = tbl_q[rx_ch];

`ifdef A2D_NOISE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= LFSR_SEED;
        else if (done_d)
            lfsr_q <= lfsr_next(lfsr_q);
    end

    assign pend_new = add_noise(sampled, lfsr_q[3:0]);
`else
    assign pend_new = sampled;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) tbl_q[i] <= RST_VAL;
        end else if (wr_en) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            pend_q    <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            pend_q    <= pend_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        pend_d    = pend_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    tx_d      = {4'b0000, pend_q};
                    rx_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // SS_n rise takes priority over any SCLK edge in the same cycle
                if (ss_rise) begin
                    if (bit_cnt_q == BIT_GOOD) begin
                        last_d = rx_ch;
                        pend_d = pend_new;
                        cnt_d  = cnt_q + 16'd1;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d = {rx_q[FRAME_BITS-3:0], mosi_s};
                    if (bit_cnt_q != BIT_SAT)
                        bit_cnt_d = bit_cnt_q + 5'd1;
                end else if (sclk_fall && bit_cnt_q != '0) begin
                    tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MISO       = (state_q == SHIFT) ? tx_q[FRAME_BITS-1] : 1'b1;
    assign xact_done  = done_q;
    assign frame_err  = err_q;
    assign last_chnnl = last_q;
    assign xact_cnt   = cnt_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: bit-banged SPI master with hand-computed
// expected frames; the dither range test runs only with A2D_NOISE_EN.
module tb_a2d_spi_resp;

    localparam int HP = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n, SCLK, MOSI, MISO;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic        xact_done, frame_err;
    logic [2:0]  last_chnnl;
    logic [15:0] xact_cnt;

    int checks   = 0;
    int failures = 0;

    a2d_spi_resp #(.RST_VAL(12'h000), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .xact_done(xact_done), .frame_err(frame_err),
        .last_chnnl(last_chnnl), .xact_cnt(xact_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic write_tbl(input logic [2:0] a, input logic [11:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_frame(input logic [15:0] mosi_w, input int nrise,
                            output logic [15:0] miso_w, output int n_done, output int n_err);
        miso_w = '0; n_done = 0; n_err = 0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? mosi_w[15-i] : 1'b0;
            repeat (HP) @(negedge clk);
            if (i < 16) miso_w[15-i] = MISO;
            SCLK = 1'b1;
            repeat (HP) @(negedge clk);
        end
        SS_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (xact_done) n_done++;
            if (frame_err) n_err++;
        end
        MOSI = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (MISO !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", MISO); end
        checks++; if (xact_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", xact_done); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        checks++; if (last_chnnl !== 3'd0) begin failures++; $display("FAIL reset_last got=%0d exp=0", last_chnnl); end
        checks++; if (xact_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", xact_cnt); end
    endtask

    task automatic test_first_frame();
        logic [15:0] m; int nd, ne;
        do_frame(cmd(3'd0), 16, m, nd, ne);
        checks++; if (m !== 16'h0000) begin failures++; $display("FAIL first_miso got=%h exp=0000", m); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL first_done got=%0d exp=1", nd); end
        checks++; if (ne !== 0) begin failures++; $display("FAIL first_err got=%0d exp=0", ne); end
        checks++; if (xact_cnt !== 16'd1) begin failures++; $display("FAIL first_cnt got=%0d exp=1", xact_cnt); end
        checks++; if (last_chnnl !== 3'd0) begin failures++; $display("FAIL first_last got=%0d exp=0", last_chnnl); end
        checks++; if (MISO !== 1'b1) begin failures++; $display("FAIL first_idle_miso got=%b exp=1", MISO); end
    endtask

    task automatic test_table_write();
        logic [15:0] m; int nd, ne;
        write_tbl(3'd5, 12'hA5C);
        do_frame(cmd(3'd5), 16, m, nd, ne);
        checks++; if (m !== 16'h0000) begin failures++; $display("FAIL tw_first_miso got=%h exp=0000", m); end
        checks++; if (last_chnnl !== 3'd5) begin failures++; $display("FAIL tw_last5 got=%0d exp=5", last_chnnl); end
        do_frame(cmd(3'd2), 16, m, nd, ne);
        checks++; if (m !== 16'h0A5C) begin failures++; $display("FAIL tw_miso got=%h exp=0a5c", m); end
        checks++; if (last_chnnl !== 3'd2) begin failures++; $display("FAIL tw_last2 got=%0d exp=2", last_chnnl); end
        checks++; if (xact_cnt !== 16'd3) begin failures++; $display("FAIL tw_cnt got=%0d exp=3", xact_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m, exp; int nd, ne;
        apply_reset();
        for (int i = 0; i < 8; i++) write_tbl(3'(i), 12'(i * 12'h101));
        for (int i = 0; i < 8; i++) begin
            exp = (i == 0) ? 16'h0000 : 16'((i - 1) * 12'h101);
            do_frame(cmd(3'(i)), 16, m, nd, ne);
            checks++; if (m !== exp) begin failures++; $display("FAIL sweep_miso ch=%0d got=%h exp=%h", i, m, exp); end
        end
        checks++; if (xact_cnt !== 16'd8) begin failures++; $display("FAIL sweep_cnt got=%0d exp=8", xact_cnt); end
        checks++; if (last_chnnl !== 3'd7) begin failures++; $display("FAIL sweep_last got=%0d exp=7", last_chnnl); end
        do_frame(cmd(3'd3), 16, m, nd, ne);
        checks++; if (m !== 16'h0707) begin failures++; $display("FAIL sweep_tail_miso got=%h exp=0707", m); end
    endtask

    task automatic test_abort();
        logic [15:0] m; int nd, ne;
        do_frame(cmd(3'd6), 9, m, nd, ne);
        checks++; if (ne !== 1) begin failures++; $display("FAIL abort9_err got=%0d exp=1", ne); end
        checks++; if (nd !== 0) begin failures++; $display("FAIL abort9_done got=%0d exp=0", nd); end
        checks++; if (xact_cnt !== 16'd9) begin failures++; $display("FAIL abort9_cnt got=%0d exp=9", xact_cnt); end
        checks++; if (last_chnnl !== 3'd3) begin failures++; $display("FAIL abort9_last got=%0d exp=3", last_chnnl); end
        do_frame(cmd(3'd1), 16, m, nd, ne);
        checks++; if (m !== 16'h0303) begin failures++; $display("FAIL abort9_next got=%h exp=0303", m); end
        do_frame(cmd(3'd2), 17, m, nd, ne);
        checks++; if (ne !== 1) begin failures++; $display("FAIL abort17_err got=%0d exp=1", ne); end
        checks++; if (nd !== 0) begin failures++; $display("FAIL abort17_done got=%0d exp=0", nd); end
        do_frame(cmd(3'd0), 16, m, nd, ne);
        checks++; if (m !== 16'h0101) begin failures++; $display("FAIL abort17_next got=%h exp=0101", m); end
        checks++; if (xact_cnt !== 16'd11) begin failures++; $display("FAIL abort_cnt got=%0d exp=11", xact_cnt); end
        checks++; if (last_chnnl !== 3'd0) begin failures++; $display("FAIL abort_last got=%0d exp=0", last_chnnl); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] m, w; int nd, ne;
        w = cmd(3'd4);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            SCLK = 1'b0; MOSI = w[15-i];
            repeat (HP) @(negedge clk);
            SCLK = 1'b1;
            repeat (HP) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (MISO !== 1'b1) begin failures++; $display("FAIL midrst_miso got=%b exp=1", MISO); end
        checks++; if (xact_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", xact_cnt); end
        checks++; if (last_chnnl !== 3'd0) begin failures++; $display("FAIL midrst_last got=%0d exp=0", last_chnnl); end
        @(negedge clk);
        SS_n = 1'b1; MOSI = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        nd = 0; ne = 0;
        repeat (10) begin
            @(negedge clk);
            if (xact_done) nd++;
            if (frame_err) ne++;
        end
        checks++; if (nd + ne !== 0) begin failures++; $display("FAIL midrst_pulse got=%0d exp=0", nd + ne); end
        do_frame(cmd(3'd4), 16, m, nd, ne);
        checks++; if (m !== 16'h0000) begin failures++; $display("FAIL midrst_next got=%h exp=0000", m); end
        checks++; if (xact_cnt !== 16'd1) begin failures++; $display("FAIL midrst_next_cnt got=%0d exp=1", xact_cnt); end
    endtask

    task automatic test_noise();
        logic [15:0] m; int nd, ne;
        apply_reset();
        write_tbl(3'd3, 12'hFFE);
        do_frame(cmd(3'd3), 16, m, nd, ne);
        checks++; if (m !== 16'h0000) begin failures++; $display("FAIL noise_first got=%h exp=0000", m); end
        for (int i = 0; i < 200; i++) begin
            do_frame(cmd(3'd3), 16, m, nd, ne);
            checks++;
            if (m < 16'h0FF6 || m > 16'h0FFF) begin
                failures++;
                $display("FAIL noise_range frame=%0d got=%h exp=0ff6..0fff", i, m);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
`ifdef A2D_NOISE_EN
        test_noise();
`else
        test_first_frame();
        test_table_write();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
